// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared types and helpers for the multiplier-sharing arbiter.
//   prod_t  : signed 16-bit product
//   opnd_t  : signed 8-bit operand
//   pick_t  : round-robin pick result (found flag + winner index)
//   rr_pick : first valid requester at or above ptr, wrapping modulo nreq
package mult_arb_pkg;

    localparam int PROD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [7:0]        opnd_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 nreq);
        pick_t r;
        int    idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < nreq && !r.found) begin
                idx = (int'(ptr) + k) % nreq;
                if (valid[idx[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/SignedMultiplier8x8.sv
// SignedMultiplier8x8
// Purely combinational 8x8 two's-complement multiplier.
//   a, b : signed 8-bit operands
//   p    : signed 16-bit product (always exact, -128*-128 = +16384 fits)
module SignedMultiplier8x8 (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);

    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;

    assign a_ext = 16'(a);
    assign b_ext = 16'(b);
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/mult_arb_rr_arbiter.sv
// rr_arbiter
// NREQ-wide round-robin picker with its rotating pointer register.
//   clk, rst  : clock, async active-high reset (pointer returns to 0)
//   en        : grants allowed this cycle
//   req_valid : per-requester request
//   grant     : one-hot grant (zero when en is low or nothing is pending)
//   gnt_valid : a grant is issued this cycle
//   gnt_id    : index of the granted requester
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] ptr;
    pick_t          pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), 3'(ptr), NREQ);
        gnt_valid = en & pick.found;
        gnt_id    = IDW'(pick.idx);
        grant     = '0;
        if (gnt_valid) grant[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one SignedMultiplier8x8 between NREQ requesters. A round-robin
// grant loads stage 1 with the winner's operands; stages 2..LAT carry the
// product. The whole pipe freezes while the response is backpressured.
// Optional build macro: MULT_ARB_STALL_CNT_EN adds stall_clr / stall_cnt.
//   clk, rst            : clock, async active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : 8-bit signed operand slices, slice i = requester i
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_p       : owning requester and signed 16-bit product
//   stall_clr/stall_cnt : (macro only) clear / saturating count of cycles
//                         stalled while some request is pending
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [PROD_W-1:0] rsp_p
`ifdef MULT_ARB_STALL_CNT_EN
    ,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
`endif
);

    logic           stall;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    logic [LAT:1]   s_vld;
    logic [IDW-1:0] s_id [1:LAT];
    opnd_t          s1_a;
    opnd_t          s1_b;
    prod_t          mult_p;

    assign rsp_valid = s_vld[LAT];
    assign rsp_id    = s_id[LAT];
    assign stall     = rsp_valid & ~rsp_ready;

    // rst gates the grant so req_ready reads zero throughout reset.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall & ~rst),
        .req_valid (req_valid),
        .grant     (req_ready),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_vld <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            for (int k = 1; k <= LAT; k++) s_id[k] <= '0;
        end else if (!stall) begin
            s_vld[1] <= gnt_valid;
            s_id[1]  <= gnt_id;
            if (gnt_valid) begin
                s1_a <= req_a[8*gnt_id +: 8];
                s1_b <= req_b[8*gnt_id +: 8];
            end
            for (int k = 2; k <= LAT; k++) begin
                s_vld[k] <= s_vld[k-1];
                s_id[k]  <= s_id[k-1];
            end
        end
    end

    SignedMultiplier8x8 u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (mult_p)
    );

    generate
        if (LAT == 1) begin : g_lat1
            assign rsp_p = mult_p;
        end else begin : g_latn
            prod_t s_p [2:LAT];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 2; k <= LAT; k++) s_p[k] <= '0;
                end else if (!stall) begin
                    s_p[2] <= mult_p;
                    for (int k = 3; k <= LAT; k++) s_p[k] <= s_p[k-1];
                end
            end
            assign rsp_p = s_p[LAT];
        end
    endgenerate

`ifdef MULT_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall && (|req_valid) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
